// File: rtl/axis_dsnk_pkt_if.sv
// rtl/axis_dsnk_pkt_if.sv - stream handshake bundle between a packet source and the sink/checker
interface axis_dsnk_pkt_if #(
  parameter int NUM_BYTES = 4
);
  logic                   tvalid;
  logic [8*NUM_BYTES-1:0] tdata;
  logic                   tlast;
  logic                   tready;

  modport master (output tvalid, output tdata, output tlast, input tready);
  modport slave  (input tvalid, input tdata, input tlast, output tready);
endinterface

// File: rtl/axis_dsnk_pkt.sv
// rtl/axis_dsnk_pkt.sv - stream packet sink: programmable backpressure, length/data checks, counters
module axis_dsnk_pkt #(
  parameter int C_S_AXIS_TDATA_NUM_BYTES = 4,
  parameter bit C_CNT_SATURATE           = 1'b1
) (
  input  logic                                    AXIS_ACLK,
  input  logic                                    AXIS_ARESET,
  axis_dsnk_pkt_if.slave                          s_axis,
  input  logic [31:0]                             cmd,
  input  logic                                    new_cmd,
  input  logic [31:0]                             num_bytes,
  input  logic [31:0]                             data_type,
  input  logic [31:0]                             num_pkts,
  input  logic [31:0]                             ready_mask,
  output logic [31:0]                             stat,
  output logic [31:0]                             rx_cnt,
  output logic [31:0]                             rx_pkt_cnt,
  output logic [31:0]                             data_err_cnt,
  output logic [31:0]                             len_err_cnt,
  output logic [8*C_S_AXIS_TDATA_NUM_BYTES-1:0]   first_err_data,
  output logic [8*C_S_AXIS_TDATA_NUM_BYTES-1:0]   first_err_exp
);
  localparam int W = 8 * C_S_AXIS_TDATA_NUM_BYTES;
  localparam logic [31:0]  BEAT_BYTES = 32'(C_S_AXIS_TDATA_NUM_BYTES);
  localparam logic [W-1:0] ONE = W'(1);

  typedef enum logic [1:0] {IDLE, RECV, DONE} state_e;

  state_e       state_q, state_d;
  logic         rx_enable_q, rx_enable_d;
  logic         seed_vld_q, seed_vld_d;
  logic         first_err_vld_q, first_err_vld_d;
  logic [31:0]  rot_q, rot_d;
  logic [31:0]  rx_cnt_q, rx_cnt_d;
  logic [31:0]  rx_pkt_cnt_q, rx_pkt_cnt_d;
  logic [31:0]  data_err_cnt_q, data_err_cnt_d;
  logic [31:0]  len_err_cnt_q, len_err_cnt_d;
  logic [W-1:0] exp_q, exp_d;
  logic [W-1:0] first_err_data_q, first_err_data_d;
  logic [W-1:0] first_err_exp_q, first_err_exp_d;

  logic         tready;
  logic         xfr;
  logic         clear;
  logic         mismatch;
  logic [31:0]  rx_cnt_inc;
  logic [31:0]  pkt_inc;

  function automatic logic [31:0] cnt_inc(input logic [31:0] c);
    if (C_CNT_SATURATE && (c == 32'hFFFF_FFFF)) return c;
    return c + 32'd1;
  endfunction

  function automatic logic [W-1:0] step(input logic [W-1:0] v, input logic [31:0] dt);
    return (dt == 32'd1) ? (v - ONE) : (v + ONE);
  endfunction

  assign tready        = rx_enable_q & (state_q != DONE) & rot_q[0];
  assign s_axis.tready = tready;
  assign xfr           = s_axis.tvalid & tready;
  assign clear         = new_cmd & (cmd == 32'd2);

  always_comb begin
    state_d          = state_q;
    rx_enable_d      = rx_enable_q;
    seed_vld_d       = seed_vld_q;
    first_err_vld_d  = first_err_vld_q;
    rot_d            = rot_q;
    rx_cnt_d         = rx_cnt_q;
    rx_pkt_cnt_d     = rx_pkt_cnt_q;
    data_err_cnt_d   = data_err_cnt_q;
    len_err_cnt_d    = len_err_cnt_q;
    exp_d            = exp_q;
    first_err_data_d = first_err_data_q;
    first_err_exp_d  = first_err_exp_q;
    mismatch         = 1'b0;
    rx_cnt_inc       = rx_cnt_q + BEAT_BYTES;
    pkt_inc          = cnt_inc(rx_pkt_cnt_q);

    if (rx_enable_q) rot_d = {rot_q[0], rot_q[31:1]};
    if (new_cmd && (cmd == 32'd1)) begin
      rx_enable_d = 1'b1;
      rot_d       = (ready_mask == 32'd0) ? 32'hFFFF_FFFF : ready_mask;
    end
    if (new_cmd && (cmd == 32'd3)) rx_enable_d = 1'b0;

    if (xfr) begin
      mismatch   = seed_vld_q && (data_type != 32'd2) && (s_axis.tdata != exp_q);
      seed_vld_d = 1'b1;
      // A corrupt beat advances from the expected value so the following good beat still matches.
      exp_d      = mismatch ? step(exp_q, data_type) : step(s_axis.tdata, data_type);
      if (mismatch) begin
        data_err_cnt_d = cnt_inc(data_err_cnt_q);
        if (!first_err_vld_q) begin
          first_err_vld_d  = 1'b1;
          first_err_data_d = s_axis.tdata;
          first_err_exp_d  = exp_q;
        end
      end
      rx_cnt_d = rx_cnt_inc;
      if (state_q == IDLE) state_d = RECV;
      if (s_axis.tlast) begin
        if (rx_cnt_inc != num_bytes) len_err_cnt_d = cnt_inc(len_err_cnt_q);
        rx_pkt_cnt_d = pkt_inc;
        rx_cnt_d     = 32'd0;
        if ((num_pkts != 32'd0) && (pkt_inc == num_pkts)) state_d = DONE;
      end
    end

    if (clear) begin
      state_d          = IDLE;
      rx_enable_d      = 1'b0;
      seed_vld_d       = 1'b0;
      first_err_vld_d  = 1'b0;
      rot_d            = 32'd0;
      rx_cnt_d         = 32'd0;
      rx_pkt_cnt_d     = 32'd0;
      data_err_cnt_d   = 32'd0;
      len_err_cnt_d    = 32'd0;
      exp_d            = '0;
      first_err_data_d = '0;
      first_err_exp_d  = '0;
    end
  end

  always_ff @(posedge AXIS_ACLK) begin
    if (AXIS_ARESET) begin
      state_q          <= IDLE;
      rx_enable_q      <= 1'b0;
      seed_vld_q       <= 1'b0;
      first_err_vld_q  <= 1'b0;
      rot_q            <= 32'd0;
      rx_cnt_q         <= 32'd0;
      rx_pkt_cnt_q     <= 32'd0;
      data_err_cnt_q   <= 32'd0;
      len_err_cnt_q    <= 32'd0;
      exp_q            <= '0;
      first_err_data_q <= '0;
      first_err_exp_q  <= '0;
    end else begin
      state_q          <= state_d;
      rx_enable_q      <= rx_enable_d;
      seed_vld_q       <= seed_vld_d;
      first_err_vld_q  <= first_err_vld_d;
      rot_q            <= rot_d;
      rx_cnt_q         <= rx_cnt_d;
      rx_pkt_cnt_q     <= rx_pkt_cnt_d;
      data_err_cnt_q   <= data_err_cnt_d;
      len_err_cnt_q    <= len_err_cnt_d;
      exp_q            <= exp_d;
      first_err_data_q <= first_err_data_d;
      first_err_exp_q  <= first_err_exp_d;
    end
  end

  assign stat = {28'h0, first_err_vld_q,
                 (data_err_cnt_q != 32'd0) | (len_err_cnt_q != 32'd0),
                 state_q == DONE, rx_enable_q};
  assign rx_cnt         = rx_cnt_q;
  assign rx_pkt_cnt     = rx_pkt_cnt_q;
  assign data_err_cnt   = data_err_cnt_q;
  assign len_err_cnt    = len_err_cnt_q;
  assign first_err_data = first_err_data_q;
  assign first_err_exp  = first_err_exp_q;
endmodule

// File: tb/tb_axis_dsnk_pkt.sv
// tb/tb_axis_dsnk_pkt.sv - scoreboard bench for the stream packet sink/checker
module tb_axis_dsnk_pkt;
  logic        clk;
  logic        rst;
  logic [31:0] cmd, num_bytes, data_type, num_pkts, ready_mask;
  logic        new_cmd;
  logic [31:0] stat, rx_cnt, rx_pkt_cnt, data_err_cnt, len_err_cnt;
  logic [31:0] first_err_data, first_err_exp;

  axis_dsnk_pkt_if #(.NUM_BYTES(4)) s_axis ();

  axis_dsnk_pkt #(.C_S_AXIS_TDATA_NUM_BYTES(4), .C_CNT_SATURATE(1'b1)) dut (
    .AXIS_ACLK(clk), .AXIS_ARESET(rst), .s_axis(s_axis),
    .cmd(cmd), .new_cmd(new_cmd), .num_bytes(num_bytes), .data_type(data_type),
    .num_pkts(num_pkts), .ready_mask(ready_mask), .stat(stat), .rx_cnt(rx_cnt),
    .rx_pkt_cnt(rx_pkt_cnt), .data_err_cnt(data_err_cnt), .len_err_cnt(len_err_cnt),
    .first_err_data(first_err_data), .first_err_exp(first_err_exp)
  );

  typedef struct {
    logic [31:0] pkt;
    logic [31:0] derr;
    logic [31:0] lerr;
  } exp_t;

  exp_t sb_q[$];
  exp_t sb_e;
  int   n_cmp = 0;
  int   n_bad = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, want);
    end
  endtask

  // End-of-packet results are compared one cycle after the TLAST beat is accepted.
  always @(posedge clk) begin
    if (!rst && s_axis.tvalid && s_axis.tready && s_axis.tlast && !(new_cmd && cmd == 32'd2)) begin
      #1;
      if (sb_q.size() == 0) begin
        check("sb_underflow", 32'd1, 32'd0);
      end else begin
        sb_e = sb_q.pop_front();
        check("sb_pkt_cnt", rx_pkt_cnt, sb_e.pkt);
        check("sb_data_err", data_err_cnt, sb_e.derr);
        check("sb_len_err", len_err_cnt, sb_e.lerr);
        check("sb_rx_cnt", rx_cnt, 32'd0);
      end
    end
  end

  task automatic push_exp(input int p, input int d, input int l);
    exp_t e;
    e.pkt  = 32'(p);
    e.derr = 32'(d);
    e.lerr = 32'(l);
    sb_q.push_back(e);
  endtask

  task automatic do_cmd(input logic [31:0] c);
    cmd     = c;
    new_cmd = 1'b1;
    @(negedge clk);
    new_cmd = 1'b0;
  endtask

  task automatic cfg(input int nb, input int dt, input int np, input logic [31:0] mask);
    num_bytes  = 32'(nb);
    data_type  = 32'(dt);
    num_pkts   = 32'(np);
    ready_mask = mask;
  endtask

  task automatic idle();
    s_axis.tvalid = 1'b0;
    s_axis.tlast  = 1'b0;
  endtask

  // Called at a negedge; returns at the negedge after the beat was accepted with tvalid still high.
  task automatic send_beat(input logic [31:0] d, input logic l);
    int n = 0;
    s_axis.tvalid = 1'b1;
    s_axis.tdata  = d;
    s_axis.tlast  = l;
    while (!s_axis.tready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("beat_timeout", 32'd1, 32'd0);
    @(negedge clk);
  endtask

  task automatic send_pkt(input int base, input int nbeats, input int bad_idx,
                          input logic [31:0] bad_val, input int p, input int de, input int le);
    logic [31:0] d;
    for (int i = 0; i < nbeats; i++) begin
      d = (i == bad_idx) ? bad_val : 32'(base + i);
      if (i == nbeats - 1) push_exp(p, de, le);
      send_beat(d, i == nbeats - 1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int beat;
    logic exp_rdy;
    rst = 1'b1;
    new_cmd = 1'b0;
    cmd = 32'd0;
    cfg(0, 0, 0, 32'd0);
    s_axis.tdata = 32'd0;
    idle();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_stat", stat, 32'd0);
    check("rst_tready", 32'(s_axis.tready), 32'd0);
    check("rst_pkt_cnt", rx_pkt_cnt, 32'd0);
    check("rst_rx_cnt", rx_cnt, 32'd0);

    // 1: three clean packets then done
    cfg(16, 0, 3, 32'd0);
    do_cmd(32'd1);
    check("t1_tready_on", 32'(s_axis.tready), 32'd1);
    send_pkt(5, 4, -1, 32'd0, 1, 0, 0);
    send_pkt(9, 4, -1, 32'd0, 2, 0, 0);
    send_pkt(13, 4, -1, 32'd0, 3, 0, 0);
    check("t1_tready_done", 32'(s_axis.tready), 32'd0);
    idle();
    check("t1_stat", stat, 32'h3);
    check("t1_pkt_cnt", rx_pkt_cnt, 32'd3);

    // 2: one corrupt beat gives exactly one data error
    do_cmd(32'd2);
    check("t2_clr_stat", stat, 32'd0);
    do_cmd(32'd1);
    send_pkt(5, 4, -1, 32'd0, 1, 0, 0);
    send_pkt(9, 4, 1, 32'hDEAD, 2, 1, 0);
    send_pkt(13, 4, -1, 32'd0, 3, 1, 0);
    idle();
    check("t2_data_err", data_err_cnt, 32'd1);
    check("t2_first_exp", first_err_exp, 32'd10);
    check("t2_first_data", first_err_data, 32'hDEAD);
    check("t2_stat", stat, 32'hF);

    // 3: short packet raises a length error, next packet is clean
    do_cmd(32'd2);
    cfg(16, 0, 0, 32'd0);
    do_cmd(32'd1);
    send_pkt(100, 3, -1, 32'd0, 1, 0, 1);
    idle();
    check("t3_rx_cnt", rx_cnt, 32'd0);
    send_pkt(103, 4, -1, 32'd0, 2, 0, 1);
    idle();
    check("t3_len_err", len_err_cnt, 32'd1);
    check("t3_stat", stat, 32'h5);

    // 4: ready_mask 5 gives a period-32 ready pattern with valid held high
    do_cmd(32'd2);
    cfg(16, 0, 0, 32'h5);
    do_cmd(32'd1);
    beat = 0;
    for (int j = 0; j < 40; j++) begin
      exp_rdy = ((j % 32) == 0) || ((j % 32) == 2);
      check($sformatf("t4_ready_%0d", j), 32'(s_axis.tready), 32'(exp_rdy));
      s_axis.tvalid = 1'b1;
      s_axis.tdata  = 32'(40 + beat);
      s_axis.tlast  = (beat == 3);
      if (s_axis.tready) begin
        if (beat == 3) push_exp(1, 0, 0);
        beat++;
      end
      @(negedge clk);
    end
    idle();
    check("t4_pkt_cnt", rx_pkt_cnt, 32'd1);
    check("t4_data_err", data_err_cnt, 32'd0);

    // 5: disable mid-packet, then resume
    do_cmd(32'd2);
    cfg(16, 0, 0, 32'd0);
    do_cmd(32'd1);
    send_beat(32'd200, 1'b0);
    send_beat(32'd201, 1'b0);
    idle();
    do_cmd(32'd3);
    s_axis.tvalid = 1'b1;
    s_axis.tdata  = 32'd202;
    for (int j = 0; j < 4; j++) begin
      check("t5_tready_off", 32'(s_axis.tready), 32'd0);
      @(negedge clk);
    end
    check("t5_rx_cnt", rx_cnt, 32'd8);
    do_cmd(32'd1);
    send_beat(32'd202, 1'b0);
    push_exp(1, 0, 0);
    send_beat(32'd203, 1'b1);
    idle();
    check("t5_len_err", len_err_cnt, 32'd0);
    check("t5_data_err", data_err_cnt, 32'd0);

    // 6: reset together with a clear strobe mid-packet
    do_cmd(32'd2);
    do_cmd(32'd1);
    send_beat(32'd300, 1'b0);
    send_beat(32'd301, 1'b0);
    s_axis.tdata = 32'd302;
    rst     = 1'b1;
    cmd     = 32'd2;
    new_cmd = 1'b1;
    @(negedge clk);
    rst     = 1'b0;
    new_cmd = 1'b0;
    idle();
    check("t6_stat", stat, 32'd0);
    check("t6_rx_cnt", rx_cnt, 32'd0);
    check("t6_pkt_cnt", rx_pkt_cnt, 32'd0);
    check("t6_data_err", data_err_cnt, 32'd0);
    do_cmd(32'd1);
    send_pkt(500, 4, -1, 32'd0, 1, 0, 0);
    idle();
    check("t6_reseed_err", data_err_cnt, 32'd0);

    repeat (3) @(negedge clk);
    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
